// File: rtl/multi_gate_pipe.sv
// N-input gate with a constant bubble mask, runtime-selected reduction and a
// two-stage registered pipeline with valid/ready flow control on both sides.
module multi_gate_pipe #(
  parameter int                    NUM_INPUTS   = 4,
  parameter logic [NUM_INPUTS-1:0] BUBBLES_MASK = {NUM_INPUTS{1'b0}},
  parameter bit                    MAJ_TIE_HIGH = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] in_data,
  input  logic [2:0]            in_func,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_result,
  output logic [2:0]            out_func,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int            CW     = $clog2(NUM_INPUTS + 1);
  localparam logic [CW-1:0] HALF   = CW'(NUM_INPUTS / 2);
  localparam bit            EVEN_N = ((NUM_INPUTS % 2) == 0);

  function automatic logic [CW-1:0] popcount(input logic [NUM_INPUTS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // Majority ties exist only for even N; MAJ_TIE_HIGH decides them.
  function automatic logic reduce(input logic [NUM_INPUTS-1:0] m, input logic [2:0] f);
    logic [CW-1:0] pc;
    logic          res;
    pc = popcount(m);
    case (f)
      3'd0:    res = |m;
      3'd1:    res = &m;
      3'd2:    res = ^m;
      3'd3:    res = ~|m;
      3'd4:    res = ~&m;
      3'd5:    res = ~^m;
      3'd6:    res = (pc > HALF) || (EVEN_N && (pc == HALF) && MAJ_TIE_HIGH);
      3'd7:    res = (pc == CW'(1));
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [NUM_INPUTS-1:0] r_s1_data;
  logic [2:0]            r_s1_func;
  logic                  r_s1_valid;
  logic                  r_out_result;
  logic [2:0]            r_out_func;
  logic                  r_out_valid;

  logic w_s2_en;
  logic w_s1_en;

  assign w_s2_en  = ~r_out_valid | out_ready;
  assign w_s1_en  = ~r_s1_valid | w_s2_en;
  assign in_ready = w_s1_en;

  assign out_result = r_out_result;
  assign out_func   = r_out_func;
  assign out_valid  = r_out_valid;

  // Stage 1 captures the masked operand; stage 2 reduces it into the output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_data    <= {NUM_INPUTS{1'b0}};
      r_s1_func    <= 3'd0;
      r_s1_valid   <= 1'b0;
      r_out_result <= 1'b0;
      r_out_func   <= 3'd0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_s1_en) begin
        if (in_valid) begin
          r_s1_data  <= in_data ^ BUBBLES_MASK;
          r_s1_func  <= in_func;
          r_s1_valid <= 1'b1;
        end else begin
          r_s1_valid <= 1'b0;
        end
      end
      if (w_s2_en) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_result <= reduce(r_s1_data, r_s1_func);
          r_out_func   <= r_s1_func;
        end
      end
    end
  end

endmodule

// File: doc/multi_gate_pipe.md
Name: multi_gate_pipe

Overview:
- Parametrised successor to the two-input bubble-mask logic gate.
- N-input gate with:
  - a per-input inversion (bubble) mask;
  - a runtime-selectable reduction function (OR/AND/XOR/NOR/NAND/XNOR/majority/one-hot);
  - a 2-stage registered pipeline with valid/ready handshake on both sides.
- Sits between Logisim-generated combinational logic and synchronous consumers that need registered, flow-controlled results.

Parameters:
- NUM_INPUTS, 4, input vector width; legal range 2..32.
- BUBBLES_MASK, 0, NUM_INPUTS-bit mask; bit i = 1 inverts in_data[i] before reduction.
- MAJ_TIE_HIGH, 0, majority result when popcount equals exactly NUM_INPUTS/2 (even N only); 1 → result 1, 0 → result 0.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_INPUTS  operand bits.
- in_func  input  3  function select, sampled with in_data.
- in_valid  input  1  producer has an operand.
- in_ready  output  1  block accepts operand this cycle.
- out_result  output  1  registered gate result.
- out_func  output  3  function code that produced out_result.
- out_valid  output  1  out_result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: sampled on the rising clock edge, no asynchronous path.
  - While reset is high at an edge:
    - s1_valid, s2_valid, out_valid ← 0;
    - out_result ← 0, out_func ← 0;
    - stage-1 data registers ← 0.
  - in_ready is combinational, so it follows the cleared valids and reads 1 during reset.
  - Reset mid-operation discards all in-flight operands. No result is emitted for them.
- Bubbles:
  - m = in_data ^ BUBBLES_MASK, applied before stage-1 capture.
  - The mask is a constant; there is no runtime mask.
- Stage 1 (capture):
  - On accept (in_valid & in_ready), store m and in_func, and set s1_valid.
  - When stage 1 hands off without a new accept, clear s1_valid.
- Stage 2 (reduce + output):
  - On s2_en & s1_valid, compute f(m, func), register it into out_result/out_func, and set out_valid.
- Function codes:
  - 0 OR: |m.
  - 1 AND: &m.
  - 2 XOR: ^m.
  - 3 NOR: ~|m.
  - 4 NAND: ~&m.
  - 5 XNOR: ~^m.
  - 6 MAJ: popcount(m) > N/2. For even N, a tie (popcount == N/2) yields MAJ_TIE_HIGH.
  - 7 ONEHOT: popcount(m) == 1.
- Popcount width is clog2(NUM_INPUTS+1) bits, unsigned, with no overflow possible.
- Flow control:
  - s2_en = ~out_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en.
  - The ready path is combinational, from out_ready to in_ready. No skid buffer.
- Latency and throughput:
  - Latency is 2 clocks from accept to out_valid, with out_ready held high.
  - Throughput is 1 result per clock at full flow.
- Backpressure:
  - While out_valid & ~out_ready, out_result and out_func hold stable.
  - At most one more operand is accepted, into stage 1; in_ready then drops.
- Simultaneous consume and accept:
  - With out_valid & out_ready and s1_valid all true, the output reloads from stage 1 in the same edge.
  - With in_valid also true, stage 1 reloads from the input in that same edge.
  - No bubble cycles are inserted.
- in_valid low: nothing is captured. Stage 1 drains normally.
- No combinational path from in_data to out_result.

Test Plan:
- Reset/idle: N=4, mask 0; hold reset 2 clocks, then release.
  → out_valid=0, out_result=0, in_ready=1 throughout.
- Function sweep: N=4, mask 0, out_ready=1; in_data=4'b0110 with func 0..7 back-to-back.
  → results 1,0,0,0,1,1,MAJ_TIE_HIGH,0, each exactly 2 clocks after its accept, one per clock.
- Bubble mask: N=4, BUBBLES_MASK=4'b0011; in_data=4'b0011, func=0 (OR).
  → out_result=0.
  - Same mask, in_data=4'b0000, func=1 (AND) → out_result=0.
  - Same mask, in_data=4'b1100, func=1 (AND) → out_result=1.
- Backpressure: stream 4 operands, holding out_ready=0 from the first out_valid for 3 clocks.
  → out_result/out_func stable, exactly 2 operands in flight, in_ready=0.
  → after release, all 4 results arrive in order, none lost or duplicated.
- Majority odd N: N=5, func=6.
  → in_data=5'b00111 gives 1; 5'b00011 gives 0.
  - func=7 with 5'b00100 → 1; with 5'b00000 → 0.
- Reset mid-stream: assert reset while s1_valid=1 and out_valid=1.
  → next clock: out_valid=0, out_result=0.
  → no stale result appears after reset deasserts.
  → the first post-reset operand emerges with 2-clock latency.
